// File: rtl/mdu_busy_core.sv
// rtl/mdu_busy_core.sv - E-stage multiply/divide unit owning HI/LO, with busy for hazard stalls
module mdu_busy_core #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic        flush,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state;
    logic [CW-1:0]  count;
    logic [31:0]    hi_tmp;
    logic [31:0]    lo_tmp;
    logic           wr_pend;

    logic           op_valid;
    logic           accept;
    logic           is_mult;
    logic [63:0]    prod_s;
    logic [63:0]    prod_u;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0]    ub;
    logic [31:0]    res_hi;
    logic [31:0]    res_lo;
    logic           res_wr;

    assign op_valid = (md_op >= OP_MULT) && (md_op <= OP_MTLO);
    assign accept   = start & ~flush & ~busy & op_valid;
    assign is_mult  = (md_op == OP_MULT) || (md_op == OP_MULTU);

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'b0, a} * {32'b0, b};

    // Divisor forced nonzero so the datapath never evaluates x/0; the b==0 case is discarded anyway.
    assign sa = $signed(a);
    assign sb = (b == 32'd0) ? 32'sd1 : $signed(b);
    assign ub = (b == 32'd0) ? 32'd1 : b;

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        res_wr = 1'b1;
        case (md_op)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV: begin
                if (b == 32'd0) begin
                    res_wr = 1'b0;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    // The one signed overflow case: quotient wraps to the dividend, no remainder.
                    res_lo = 32'h8000_0000;
                    res_hi = 32'd0;
                end else begin
                    res_lo = sa / sb;
                    res_hi = sa % sb;
                end
            end
            OP_DIVU: begin
                if (b == 32'd0) begin
                    res_wr = 1'b0;
                end else begin
                    res_lo = a / ub;
                    res_hi = a % ub;
                end
            end
            default: res_wr = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            busy    <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            hi_tmp  <= 32'd0;
            lo_tmp  <= 32'd0;
            wr_pend <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (md_op)
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
                            default: begin
                                hi_tmp  <= res_hi;
                                lo_tmp  <= res_lo;
                                wr_pend <= res_wr;
                                count   <= is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                                state   <= RUN;
                                busy    <= 1'b1;
                            end
                        endcase
                    end
                end
                RUN: begin
                    count <= count - 1'b1;
                    if (count == CW'(1)) begin
                        if (wr_pend) begin
                            hi <= hi_tmp;
                            lo <= lo_tmp;
                        end
                        wr_pend <= 1'b0;
                        state   <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_busy_core.sv
// tb/tb_mdu_busy_core.sv - directed self-checking bench for mdu_busy_core
module tb_mdu_busy_core;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic        flush;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int failures;

    mdu_busy_core #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .flush (flush),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb,
                         input logic fl);
        start = 1'b1;
        md_op = op;
        a     = va;
        b     = vb;
        flush = fl;
        tick();
        start = 1'b0;
        md_op = 3'd0;
        flush = 1'b0;
    endtask

    // Called right after the accept edge: busy must hold for n cycles with HI/LO frozen.
    task automatic run_check(input string tag, input int n, input int flush_at,
                             input logic [31:0] old_hi, input logic [31:0] old_lo,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
            chk({tag, "_hold_hi"}, hi, old_hi);
            chk({tag, "_hold_lo"}, lo, old_lo);
            flush = (i == flush_at);
            tick();
            flush = 1'b0;
        end
        chk({tag, "_done_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_hi"}, hi, exp_hi);
        chk({tag, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        start    = 1'b0;
        md_op    = 3'd0;
        flush    = 1'b0;
        a        = 32'd0;
        b        = 32'd0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);

        // mult 3*4 killed by reset in its second busy cycle
        issue(3'd1, 32'd3, 32'd4, 1'b0);
        chk("midrst_busy1", {31'b0, busy}, 32'd1);
        tick();
        chk("midrst_busy2", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        for (int i = 0; i < 6; i++) tick();
        chk("midrst_late_busy", {31'b0, busy}, 32'd0);
        chk("midrst_late_lo", lo, 32'd0);

        issue(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        run_check("mult_neg", 5, -1, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_check("multu_max", 5, -1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'h0000_0001);
        issue(3'd4, 32'd7, 32'd2, 1'b0);
        run_check("divu_7_2", 10, -1, 32'hFFFF_FFFE, 32'h0000_0001, 32'd1, 32'd3);

        issue(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_check("div_m7_2", 10, -1, 32'd1, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_check("div_ovf", 10, -1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd0, 32'h8000_0000);

        issue(3'd5, 32'h11, 32'd0, 1'b0);
        chk("mthi11_hi", hi, 32'h11);
        chk("mthi11_busy", {31'b0, busy}, 32'd0);
        issue(3'd6, 32'h22, 32'd0, 1'b0);
        chk("mtlo22_lo", lo, 32'h22);
        chk("mtlo22_busy", {31'b0, busy}, 32'd0);
        issue(3'd3, 32'd5, 32'd0, 1'b0);
        run_check("div_by0", 10, -1, 32'h11, 32'h22, 32'h11, 32'h22);

        issue(3'd1, 32'd9, 32'd9, 1'b1);
        for (int i = 0; i < 6; i++) begin
            chk("flush_acc_busy", {31'b0, busy}, 32'd0);
            tick();
        end
        chk("flush_acc_hi", hi, 32'h11);
        chk("flush_acc_lo", lo, 32'h22);

        issue(3'd1, 32'h1234, 32'h10, 1'b0);
        run_check("flush_run", 5, 1, 32'h11, 32'h22, 32'd0, 32'h0001_2340);

        issue(3'd5, 32'hDEAD_BEEF, 32'd0, 1'b0);
        chk("mthi_dead_hi", hi, 32'hDEAD_BEEF);
        chk("mthi_dead_lo", lo, 32'h0001_2340);
        chk("mthi_dead_busy", {31'b0, busy}, 32'd0);

        issue(3'd7, 32'h5555_5555, 32'd3, 1'b0);
        chk("nop7_busy", {31'b0, busy}, 32'd0);
        tick();
        chk("nop7_busy2", {31'b0, busy}, 32'd0);
        chk("nop7_hi", hi, 32'hDEAD_BEEF);
        chk("nop7_lo", lo, 32'h0001_2340);
        issue(3'd0, 32'h5555_5555, 32'd3, 1'b0);
        chk("nop0_busy", {31'b0, busy}, 32'd0);
        chk("nop0_hi", hi, 32'hDEAD_BEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
